// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin arbiter that shares one pipelined Wishbone slave between
// NUM_MASTERS masters. A grant is held for the whole cyc burst, and a
// watchdog aborts a transfer whose slave stops acknowledging. After an abort
// the bus goes back to the pool once the aborted master drops cyc.

module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [32*NUM_MASTERS-1:0] m_data_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_stall_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               m_data_o,

    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_data_o,
    output logic [3:0]                s_sel_o,
    input  logic                      s_ack_i,
    input  logic                      s_stall_i,
    input  logic [31:0]               s_data_i,

    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int PEND_W = 8;

    localparam logic [CNT_WIDTH-1:0] WDOG_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WDOG_ONE   = CNT_WIDTH'(1);
    localparam logic [PEND_W-1:0]    PEND_ONE   = PEND_W'(1);
    localparam logic [PEND_W-1:0]    PEND_MAX   = '1;
    localparam logic [IDX_W-1:0]     PTR_INIT   = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Grant is one-hot; all zero means nobody owns the slave.
    logic [NUM_MASTERS-1:0] grant_q;
    // Index of the most recently granted master; the scan starts one past it.
    logic [IDX_W-1:0]       ptr_q;
    logic [CNT_WIDTH-1:0]   wdog_q;
    // Strobes accepted by the slave that have not been acknowledged yet.
    logic [PEND_W-1:0]      pend_q;

    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;
    logic [NUM_MASTERS-1:0] arb_onehot;

    logic                   sel_cyc;
    logic                   sel_stb;
    logic                   sel_we;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_data;
    logic [3:0]             sel_sel;

    logic                   outstanding;
    logic                   accept;
    logic                   retire;
    logic                   timeout_hit;

    // Route the granted master's request signals; zeros when nothing is granted.
    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_sel  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                sel_cyc  = m_cyc_i[k];
                sel_stb  = m_stb_i[k];
                sel_we   = m_we_i[k];
                sel_addr = m_addr_i[32*k +: 32];
                sel_data = m_data_i[32*k +: 32];
                sel_sel  = m_sel_i[4*k +: 4];
            end
        end
    end

    // Find the first requester after the pointer, wrapping round the master list.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!arb_found && m_cyc_i[k] &&
                    ((int'(ptr_q) + off) % NUM_MASTERS == k)) begin
                    arb_found     = 1'b1;
                    arb_idx       = IDX_W'(k);
                    arb_onehot    = '0;
                    arb_onehot[k] = 1'b1;
                end
            end
        end
    end

    // Watchdog qualifiers: what the slave accepts/returns this cycle and whether it has hung.
    always_comb begin
        outstanding = sel_stb || (pend_q != '0);
        accept      = (state_q == BUSY) && sel_cyc && sel_stb && !s_stall_i;
        retire      = (state_q == BUSY) && s_ack_i && ((pend_q != '0) || accept);
        timeout_hit = (state_q == BUSY) && sel_cyc && outstanding && !s_ack_i &&
                      (wdog_q == WDOG_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a release always passes through IDLE before the next grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant, round-robin pointer, watchdog and pending-ack bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            ptr_q   <= PTR_INIT;
            wdog_q  <= '0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    pend_q <= '0;
                    if (arb_found) begin
                        grant_q <= arb_onehot;
                        ptr_q   <= arb_idx;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        grant_q <= '0;
                        wdog_q  <= '0;
                        pend_q  <= '0;
                    end else if (timeout_hit) begin
                        wdog_q <= '0;
                        pend_q <= '0;
                    end else begin
                        case ({accept, retire})
                            2'b10: begin
                                if (pend_q != PEND_MAX) begin
                                    pend_q <= pend_q + PEND_ONE;
                                end
                            end
                            2'b01: begin
                                pend_q <= pend_q - PEND_ONE;
                            end
                            default: begin
                                pend_q <= pend_q;
                            end
                        endcase
                        if (s_ack_i || !outstanding) begin
                            wdog_q <= '0;
                        end else begin
                            wdog_q <= wdog_q + WDOG_ONE;
                        end
                    end
                end
                ABORT: begin
                    wdog_q <= '0;
                    pend_q <= '0;
                    if (!sel_cyc) begin
                        grant_q <= '0;
                    end
                end
                default: begin
                    grant_q <= '0;
                    wdog_q  <= '0;
                    pend_q  <= '0;
                end
            endcase
        end
    end

    // Bus outputs: only a BUSY grant reaches the slave; everyone else sees stall.
    always_comb begin
        m_ack_o   = '0;
        m_stall_o = '1;
        m_err_o   = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = sel_we;
        s_addr_o  = sel_addr;
        s_data_o  = sel_data;
        s_sel_o   = sel_sel;
        case (state_q)
            BUSY: begin
                s_cyc_o   = sel_cyc;
                s_stb_o   = sel_stb;
                m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
                m_stall_o = ~grant_q | {NUM_MASTERS{s_stall_i}};
                if (timeout_hit) begin
                    m_err_o = grant_q;
                end
            end
            default: begin
                m_ack_o   = '0;
                m_stall_o = '1;
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    always_comb begin
        m_data_o = s_data_i;
        grant_o  = grant_q;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
// Drives directed and randomized Wishbone traffic into a 3-master arbiter
// with an 8-cycle watchdog. A behavioural model predicts each cycle's outputs
// into a queue; an independent monitor pops and compares at the falling edge.

module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int T  = 8;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     m_cyc_i;
    logic [N-1:0]     m_stb_i;
    logic [N-1:0]     m_we_i;
    logic [32*N-1:0]  m_addr_i;
    logic [32*N-1:0]  m_data_i;
    logic [4*N-1:0]   m_sel_i;
    logic [N-1:0]     m_ack_o;
    logic [N-1:0]     m_stall_o;
    logic [N-1:0]     m_err_o;
    logic [31:0]      m_data_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [31:0]      s_addr_o;
    logic [31:0]      s_data_o;
    logic [3:0]       s_sel_o;
    logic             s_ack_i;
    logic             s_stall_i;
    logic [31:0]      s_data_i;
    logic [N-1:0]     grant_o;

    wb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_sel_i   (m_sel_i),
        .m_ack_o   (m_ack_o),
        .m_stall_o (m_stall_o),
        .m_err_o   (m_err_o),
        .m_data_o  (m_data_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i),
        .s_data_i  (s_data_i),
        .grant_o   (grant_o)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic [N-1:0] stall;
        logic [N-1:0] err;
        logic         s_cyc;
        logic         s_stb;
        logic [31:0]  m_data;
        bit           bus_chk;
        logic         s_we;
        logic [31:0]  s_addr;
        logic [31:0]  s_data;
        logic [3:0]   s_sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: owner of the slave (-1 when free), abort flag, last
    // winner, cycles without progress, and strobes awaiting an ack.
    int owner   = -1;
    bit aborted = 1'b0;
    int last    = N - 1;
    int wd      = 0;
    int outst   = 0;

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("grant_o",   32'(grant_o),   32'(e.grant));
        compareField("m_ack_o",   32'(m_ack_o),   32'(e.ack));
        compareField("m_stall_o", 32'(m_stall_o), 32'(e.stall));
        compareField("m_err_o",   32'(m_err_o),   32'(e.err));
        compareField("s_cyc_o",   32'(s_cyc_o),   32'(e.s_cyc));
        compareField("s_stb_o",   32'(s_stb_o),   32'(e.s_stb));
        compareField("m_data_o",  m_data_o,       e.m_data);
        if (e.bus_chk) begin
            compareField("s_we_o",   32'(s_we_o),  32'(e.s_we));
            compareField("s_addr_o", s_addr_o,     e.s_addr);
            compareField("s_data_o", s_data_o,     e.s_data);
            compareField("s_sel_o",  32'(s_sel_o), 32'(e.s_sel));
        end
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model.
    task automatic modelStep();
        exp_t e;
        bit   timeout;
        bit   active;
        e.grant   = '0;
        e.ack     = '0;
        e.stall   = '1;
        e.err     = '0;
        e.s_cyc   = 1'b0;
        e.s_stb   = 1'b0;
        e.m_data  = s_data_i;
        e.bus_chk = 1'b0;
        e.s_we    = 1'b0;
        e.s_addr  = '0;
        e.s_data  = '0;
        e.s_sel   = '0;
        timeout   = 1'b0;
        if (reset) begin
            owner   = -1;
            aborted = 1'b0;
            last    = N - 1;
            wd      = 0;
            outst   = 0;
            exp_q.push_back(e);
            return;
        end
        if (owner >= 0) begin
            e.grant[owner] = 1'b1;
            if (!aborted) begin
                e.bus_chk      = 1'b1;
                e.s_cyc        = m_cyc_i[owner];
                e.s_stb        = m_stb_i[owner];
                e.s_we         = m_we_i[owner];
                e.s_addr       = m_addr_i[32*owner +: 32];
                e.s_data       = m_data_i[32*owner +: 32];
                e.s_sel        = m_sel_i[4*owner +: 4];
                e.ack[owner]   = s_ack_i;
                e.stall[owner] = s_stall_i;
                timeout = m_cyc_i[owner] && (m_stb_i[owner] || outst > 0) &&
                          !s_ack_i && (wd == T - 1);
                e.err[owner]   = timeout;
            end
        end
        exp_q.push_back(e);

        if (owner < 0) begin
            wd    = 0;
            outst = 0;
            for (int d = 1; d <= N; d++) begin
                int k;
                k = (last + d) % N;
                if (m_cyc_i[k]) begin
                    owner = k;
                    last  = k;
                    break;
                end
            end
        end else if (!m_cyc_i[owner]) begin
            owner   = -1;
            aborted = 1'b0;
            wd      = 0;
            outst   = 0;
        end else if (aborted) begin
            wd    = 0;
            outst = 0;
        end else if (timeout) begin
            aborted = 1'b1;
            wd      = 0;
            outst   = 0;
        end else begin
            active = m_stb_i[owner] || (outst > 0);
            if (m_stb_i[owner] && !s_stall_i) outst++;
            if (s_ack_i) outst--;
            wd = (s_ack_i || !active) ? 0 : wd + 1;
        end
    endtask

    // One clock of stimulus: payload is randomized, the slave only acks real work.
    task automatic applyStimulus(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                                 input logic ack, input logic stall, input logic rst);
        logic ack_eff;
        @(posedge clk);
        #1;
        ack_eff = ack;
        if (!rst && owner >= 0 && !aborted && outst == 0) ack_eff = 1'b0;
        reset   = rst;
        m_cyc_i = cyc;
        m_stb_i = stb & cyc;
        for (int k = 0; k < N; k++) begin
            m_we_i[k]            = 1'($urandom_range(1));
            m_addr_i[32*k +: 32] = $urandom;
            m_data_i[32*k +: 32] = $urandom;
            m_sel_i[4*k +: 4]    = 4'($urandom_range(15));
        end
        s_ack_i   = ack_eff;
        s_stall_i = stall;
        s_data_i  = $urandom;
        modelStep();
    endtask

    // Monitor: compare whatever the model predicted for the cycle now settling.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios first, then a long randomized run.
    initial begin
        logic [N-1:0] cyc_r;
        logic [N-1:0] stb_r;
        bit           hang;
        reset     = 1'b1;
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_data_i  = '0;
        m_sel_i   = '0;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b0;
        s_data_i  = '0;

        $display("[TB] reset and single write from master 0");
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] simultaneous requests and round-robin hand-over");
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] four-transfer burst with a competing request");
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'b011, (i >= 1 && i <= 4) ? 3'b001 : 3'b000,
                          (i >= 2 && i <= 5), 1'b0, 1'b0);
        end
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] hung slave triggers the watchdog");
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(3'b001, 3'b001, (i >= 10), 1'b0, 1'b0);
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] ack on the timeout cycle");
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(3'b001, (i <= 1) ? 3'b001 : 3'b000, (i == 8), 1'b0, 1'b0);
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        cyc_r = '0;
        hang  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(7) == 0) cyc_r[k] = ~cyc_r[k];
                stb_r[k] = cyc_r[k] & ($urandom_range(1) == 1);
            end
            if ($urandom_range(39) == 0) hang = ~hang;
            applyStimulus(cyc_r, stb_r,
                          !hang && ($urandom_range(2) == 0),
                          ($urandom_range(3) == 0),
                          ($urandom_range(299) == 0));
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
